// File: rtl/canny_frame_seq.sv
// Frame sequencer for the canny core: feeds one frame pixel by pixel, flushes the core with
// zeros, and re-times core output into a border-masked valid/ready stream with a last flag.
module canny_frame_seq #(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int LAT    = 520,
   parameter int BORDER = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       src_valid,
   input  logic [7:0] src_data,
   output logic       src_ready,
   output logic       core_en,
   output logic [7:0] core_pixel,
   input  logic [7:0] core_out,
   output logic       dst_valid,
   output logic [7:0] dst_data,
   output logic       dst_last,
   input  logic       dst_ready,
   output logic       busy,
   output logic       done
);

   localparam int PIXELS = IMG_W * IMG_H;
   localparam int CW     = $clog2(PIXELS + LAT + 1);

   localparam logic [CW-1:0] LAST_PIX = CW'(PIXELS - 1);
   localparam logic [CW-1:0] LAT_C    = CW'(LAT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] B_C      = CW'(BORDER);
   localparam logic [CW-1:0] ROW_HI   = CW'(IMG_H - BORDER);
   localparam logic [CW-1:0] COL_HI   = CW'(IMG_W - BORDER);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] adv_cnt_q, adv_cnt_d;
   logic [CW-1:0] in_cnt_q,  in_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] out_col_q, out_col_d;
   logic [CW-1:0] out_row_q, out_row_d;

   logic feed, flush, out_phase, want, accept, xfer, in_border;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         adv_cnt_q <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         out_col_q <= '0;
         out_row_q <= '0;
      end else begin
         state_q   <= state_d;
         adv_cnt_q <= adv_cnt_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         out_col_q <= out_col_d;
         out_row_q <= out_row_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      adv_cnt_d = adv_cnt_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      out_col_d = out_col_q;
      out_row_d = out_row_q;

      if (core_en) adv_cnt_d = adv_cnt_q + 1'b1;
      if (accept)  in_cnt_d  = in_cnt_q + 1'b1;
      if (xfer) begin
         out_cnt_d = out_cnt_q + 1'b1;
         if (out_col_q == COL_LAST) begin
            out_col_d = '0;
            out_row_d = out_row_q + 1'b1;
         end else begin
            out_col_d = out_col_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FEED;
               adv_cnt_d = '0;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               out_col_d = '0;
               out_row_d = '0;
            end
         end
         S_FEED:  if (accept && in_cnt_q == LAST_PIX) state_d = S_FLUSH;
         S_FLUSH: if (xfer && out_cnt_q == LAST_PIX) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Ready/valid are combinational so the core never advances without a matching output slot.
   always_comb begin
      feed       = (state_q == S_FEED);
      flush      = (state_q == S_FLUSH);
      out_phase  = (adv_cnt_q >= LAT_C);
      want       = (feed & src_valid) | flush;
      core_en    = want & (~out_phase | dst_ready);
      src_ready  = feed & (~out_phase | dst_ready);
      dst_valid  = want & out_phase;
      dst_last   = dst_valid & (out_cnt_q == LAST_PIX);
      core_pixel = feed ? src_data : 8'h00;
      in_border  = (out_row_q < B_C) | (out_row_q >= ROW_HI) |
                   (out_col_q < B_C) | (out_col_q >= COL_HI);
      dst_data   = in_border ? 8'h00 : core_out;
      busy       = feed | flush;
      done       = (state_q == S_DONE);
      accept     = src_valid & src_ready;
      xfer       = dst_valid & dst_ready;
   end

endmodule

// File: tb/tb_canny_frame_seq.sv
// Scoreboard bench for canny_frame_seq with a delay-line stand-in for the canny core.
`timescale 1ns/1ps
module tb_canny_frame_seq;

   localparam int IMG_W  = 5;
   localparam int IMG_H  = 4;
   localparam int LAT    = 7;
   localparam int BORDER = 1;
   localparam int PIXELS = IMG_W * IMG_H;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       src_valid = 1'b0;
   logic [7:0] src_data = 8'h00;
   logic       dst_ready = 1'b0;
   logic       src_ready, core_en, dst_valid, dst_last, busy, done;
   logic [7:0] core_pixel, core_out, dst_data;

   canny_frame_seq #(.IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT), .BORDER(BORDER)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .core_en(core_en), .core_pixel(core_pixel), .core_out(core_out),
      .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Core stand-in: pixel k pushed on advance k is visible LAT advances later, xor'd with A5.
   logic [7:0] pipe [LAT];
   logic       en_s = 1'b0;
   logic [7:0] pix_s = 8'h00;
   always @(negedge clk) begin
      en_s  <= core_en;
      pix_s <= core_pixel;
   end
   always @(posedge clk) begin
      if (en_s) begin
         pipe[0] <= pix_s ^ 8'hA5;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign core_out = pipe[LAT-1];

   typedef struct { logic [7:0] data; bit last; } exp_t;
   exp_t sb_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   bit expect_active = 1'b0;
   bit feeding = 1'b0;
   int adv_base = 0;
   int adv_total = 0;
   int n_acc = 0;
   bit done_exp = 1'b0;

   function automatic void chk(string name, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [7:0] ref_pix(int k, logic [7:0] p);
      int r, c;
      r = k / IMG_W;
      c = k % IMG_W;
      if (r < BORDER || r >= IMG_H - BORDER || c < BORDER || c >= IMG_W - BORDER) return 8'h00;
      return p ^ 8'hA5;
   endfunction

   // Monitor: protocol rules per cycle, scoreboard pop on every output transfer.
   initial begin
      exp_t e;
      bit   nxt_done;
      bit   op;
      forever begin
         @(negedge clk);
         op = ((adv_total - adv_base) >= LAT);
         chk("done", int'(done), int'(done_exp));
         nxt_done = 1'b0;
         if (!expect_active) begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_src_ready", int'(src_ready), 0);
            chk("idle_core_en", int'(core_en), 0);
            chk("idle_dst_valid", int'(dst_valid), 0);
            chk("idle_dst_last", int'(dst_last), 0);
            chk("idle_core_pixel", int'(core_pixel), 0);
         end else if (feeding) begin
            chk("feed_busy", int'(busy), 1);
            chk("feed_src_ready", int'(src_ready), op ? int'(dst_ready) : 1);
            chk("feed_core_en", int'(core_en), int'(src_valid && src_ready));
            chk("feed_dst_valid", int'(dst_valid), int'(src_valid && op));
            chk("feed_core_pixel", int'(core_pixel), int'(src_data));
         end else begin
            chk("flush_busy", int'(busy), 1);
            chk("flush_src_ready", int'(src_ready), 0);
            chk("flush_core_en", int'(core_en), int'(!op || dst_ready));
            chk("flush_dst_valid", int'(dst_valid), int'(op));
            chk("flush_core_pixel", int'(core_pixel), 0);
         end
         if (dst_valid && dst_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("dst_data", int'(dst_data), int'(e.data));
               chk("dst_last", int'(dst_last), int'(e.last));
               nxt_done = e.last;
            end
         end
         if (core_en) adv_total++;
         done_exp = nxt_done;
      end
   end

   // Modes: 0 ramp full-rate, 1 dst_ready 1010, 2 five-cycle source gap,
   // 3 random with stray starts, 4 reset after 7 inputs, 5 constant data (core out FF).
   task automatic run_frame(input int mode, input bit start_in_done);
      int cyc, gap;
      bit got_last, aborted;
      @(posedge clk); #1;
      start = 1'b1; src_valid = 1'b0; dst_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; expect_active = 1'b1; feeding = 1'b1;
      adv_base = adv_total; n_acc = 0;
      cyc = 0; gap = 0; got_last = 1'b0; aborted = 1'b0;
      while (!got_last && cyc < 2000) begin
         feeding = (n_acc < PIXELS);
         start = 1'b0;
         case (mode)
            0, 4, 5: begin src_valid = 1'b1; dst_ready = 1'b1; end
            1: begin src_valid = 1'b1; dst_ready = (cyc % 2 == 0); end
            2: begin
               dst_ready = 1'b1;
               if (n_acc == 6 && gap < 5) begin src_valid = 1'b0; gap++; end
               else src_valid = 1'b1;
            end
            default: begin
               src_valid = ($urandom_range(0, 3) != 0);
               dst_ready = ($urandom_range(0, 2) != 0);
               if (feeding && $urandom_range(0, 7) == 0) start = 1'b1;
            end
         endcase
         if (mode == 5) src_data = 8'h5A;
         else if (mode <= 2) src_data = 8'(n_acc);
         else src_data = 8'($urandom);
         @(negedge clk);
         if (src_valid && src_ready) begin
            sb_q.push_back('{data: ref_pix(n_acc, src_data), last: (n_acc == PIXELS - 1)});
            n_acc++;
         end
         if (dst_valid && dst_ready && dst_last) got_last = 1'b1;
         @(posedge clk); #1;
         cyc++;
         if (mode == 4 && n_acc == 7) begin
            rst = 1'b0; expect_active = 1'b0; feeding = 1'b0; start = 1'b0;
            sb_q.delete();
            aborted = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            break;
         end
      end
      if (!aborted) begin
         chk("frame_completed", int'(got_last), 1);
         expect_active = 1'b0; feeding = 1'b0;
         src_valid = 1'b0; dst_ready = 1'b0;
         if (start_in_done) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      repeat (3) begin
         src_valid = 1'($urandom_range(0, 1));
         dst_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      src_valid = 1'b0; dst_ready = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      run_frame(0, 1'b0);
      run_frame(1, 1'b0);
      run_frame(2, 1'b0);
      run_frame(5, 1'b0);
      run_frame(3, 1'b1);
      run_frame(0, 1'b0);
      run_frame(4, 1'b0);
      run_frame(0, 1'b0);
      for (int f = 0; f < 3; f++) run_frame(3, 1'($urandom_range(0, 1)));
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
